// File: rtl/fetch_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage_if                                                   |
// | Instruction memory read handshake between IF stage and memory.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface fetch_stage_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;
  logic                 i_ready;

  modport master (output i_readM, output i_address, input i_data, input i_ready);
  modport slave  (input i_readM, input i_address, output i_data, output i_ready);
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage                                                      |
// | IF stage: PC register, imem handshake, IF/ID pipeline register.  |
// | Optional IF_PERF_CNT_EN adds fetch/flush performance counters.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_stage #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fetch_stage_if.master        imem,
  output logic [WORD_SIZE-1:0] fetch_pc,
  input  logic [WORD_SIZE-1:0] bp_pred_pc,
  input  logic                 bp_tag_match,
  input  logic                 stall_id,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 if_id_valid,
  output logic [WORD_SIZE-1:0] if_id_instr,
  output logic [WORD_SIZE-1:0] if_id_pc,
  output logic [WORD_SIZE-1:0] if_id_pred_pc,
  output logic                 if_id_tag_match
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]          perf_fetch_cnt,
  output logic [15:0]          perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

  state_t               r_state, w_state_nxt;
  logic [WORD_SIZE-1:0] r_pc, w_pc_nxt;
  logic [WORD_SIZE-1:0] r_drop_addr, w_drop_addr_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [WORD_SIZE-1:0] r_instr, w_instr_nxt;
  logic [WORD_SIZE-1:0] r_ipc, w_ipc_nxt;
  logic [WORD_SIZE-1:0] r_pred, w_pred_nxt;
  logic                 r_tag, w_tag_nxt;
  logic [WORD_SIZE-1:0] r_hold_instr, w_hold_instr_nxt;
  logic [WORD_SIZE-1:0] r_hold_pc, w_hold_pc_nxt;
  logic [WORD_SIZE-1:0] r_hold_pred, w_hold_pred_nxt;
  logic                 r_hold_tag, w_hold_tag_nxt;
  logic                 w_if_id_load;

  // A request in flight must keep its address, so S_DROP replays the abandoned one.
  assign imem.i_readM   = (r_state == S_REQ) || (r_state == S_DROP);
  assign imem.i_address = (r_state == S_DROP) ? r_drop_addr : r_pc;

  assign fetch_pc        = r_pc;
  assign if_id_valid     = r_valid;
  assign if_id_instr     = r_instr;
  assign if_id_pc        = r_ipc;
  assign if_id_pred_pc   = r_pred;
  assign if_id_tag_match = r_tag;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drop_addr_nxt  = r_drop_addr;
    w_valid_nxt      = r_valid;
    w_instr_nxt      = r_instr;
    w_ipc_nxt        = r_ipc;
    w_pred_nxt       = r_pred;
    w_tag_nxt        = r_tag;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;
    w_hold_pred_nxt  = r_hold_pred;
    w_hold_tag_nxt   = r_hold_tag;
    w_if_id_load     = 1'b0;

    if (flush) begin
      w_valid_nxt = 1'b0;
      w_pc_nxt    = redirect_pc;
      case (r_state)
        S_IDLE: w_state_nxt = S_REQ;
        S_REQ: begin
          if (!imem.i_ready) begin
            w_drop_addr_nxt = r_pc;
            w_state_nxt     = S_DROP;
          end
        end
        S_HOLD: begin
          w_hold_instr_nxt = '0;
          w_hold_pc_nxt    = '0;
          w_hold_pred_nxt  = '0;
          w_hold_tag_nxt   = 1'b0;
          w_state_nxt      = S_REQ;
        end
        default: w_state_nxt = S_DROP;
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_REQ;
        S_REQ: begin
          if (imem.i_ready) begin
            w_pc_nxt = bp_pred_pc;
            if (!stall_id) begin
              w_if_id_load = 1'b1;
              w_valid_nxt  = 1'b1;
              w_instr_nxt  = imem.i_data;
              w_ipc_nxt    = r_pc;
              w_pred_nxt   = bp_pred_pc;
              w_tag_nxt    = bp_tag_match;
            end else begin
              w_hold_instr_nxt = imem.i_data;
              w_hold_pc_nxt    = r_pc;
              w_hold_pred_nxt  = bp_pred_pc;
              w_hold_tag_nxt   = bp_tag_match;
              w_state_nxt      = S_HOLD;
            end
          end else if (!stall_id) begin
            w_valid_nxt = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall_id) begin
            w_if_id_load = 1'b1;
            w_valid_nxt  = 1'b1;
            w_instr_nxt  = r_hold_instr;
            w_ipc_nxt    = r_hold_pc;
            w_pred_nxt   = r_hold_pred;
            w_tag_nxt    = r_hold_tag;
            w_state_nxt  = S_REQ;
          end
        end
        default: begin
          if (imem.i_ready) w_state_nxt = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drop_addr  <= '0;
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_ipc        <= '0;
      r_pred       <= '0;
      r_tag        <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_hold_pred  <= '0;
      r_hold_tag   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drop_addr  <= w_drop_addr_nxt;
      r_valid      <= w_valid_nxt;
      r_instr      <= w_instr_nxt;
      r_ipc        <= w_ipc_nxt;
      r_pred       <= w_pred_nxt;
      r_tag        <= w_tag_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_hold_pred  <= w_hold_pred_nxt;
      r_hold_tag   <= w_hold_tag_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_perf_fetch_cnt;
  logic [15:0] r_perf_flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_fetch_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_if_id_load) r_perf_fetch_cnt <= r_perf_fetch_cnt + 16'd1;
      if (flush)        r_perf_flush_cnt <= r_perf_flush_cnt + 16'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_stage                                                   |
// | Directed self-checking bench for fetch_stage. Rev 1.0            |
// +------------------------------------------------------------------+
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] fetch_pc;
  logic [15:0] bp_pred_pc;
  logic        bp_tag_match;
  logic        bp_force = 1'b0;
  logic [15:0] bp_force_pc = '0;
  logic        bp_force_tag = 1'b0;
  logic        stall_id = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [15:0] if_id_instr, if_id_pc, if_id_pred_pc;
  logic        if_id_tag_match;
  logic [49:0] bundle;
  int          tests = 0;
  int          fails = 0;
`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  fetch_stage_if imem ();
  assign imem.i_ready = ready;
  assign imem.i_data  = 16'h1000 + imem.i_address;
  assign bp_pred_pc   = bp_force ? bp_force_pc : fetch_pc + 16'd1;
  assign bp_tag_match = bp_force ? bp_force_tag : 1'b0;
  assign bundle = {if_id_valid, if_id_instr, if_id_pc, if_id_pred_pc, if_id_tag_match};

  fetch_stage #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .imem(imem.master),
    .fetch_pc(fetch_pc), .bp_pred_pc(bp_pred_pc), .bp_tag_match(bp_tag_match),
    .stall_id(stall_id), .flush(flush), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pred_pc(if_id_pred_pc), .if_id_tag_match(if_id_tag_match)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (imem.i_readM !== 1'b0) begin fails++; $display("FAIL reset_readM got=%b exp=0", imem.i_readM); end
    tests++; if (fetch_pc !== 16'h0000) begin fails++; $display("FAIL reset_pc got=%h exp=0000", fetch_pc); end
    tests++; if (bundle !== 50'd0) begin fails++; $display("FAIL reset_ifid got=%h exp=0", bundle); end
    reset_n = 1'b1;
    step();
    tests++; if ({imem.i_readM, imem.i_address, if_id_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      fails++; $display("FAIL first_req got=%b/%h/%b exp=1/0000/0", imem.i_readM, imem.i_address, if_id_valid); end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 5; k++) begin
      logic [15:0] a;
      a = 16'(k);
      step();
      tests++; if (bundle !== {1'b1, 16'h1000 + a, a, a + 16'd1, 1'b0}) begin
        fails++; $display("FAIL seq_ifid[%0d] got=%h exp=%h", k, bundle, {1'b1, 16'h1000 + a, a, a + 16'd1, 1'b0}); end
      tests++; if (imem.i_address !== a + 16'd1) begin
        fails++; $display("FAIL seq_addr[%0d] got=%h exp=%h", k, imem.i_address, a + 16'd1); end
    end
  endtask

  task automatic test_not_ready();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if ({imem.i_readM, imem.i_address, if_id_valid} !== {1'b1, 16'h0005, 1'b0}) begin
        fails++; $display("FAIL wait_bubble[%0d] got=%b/%h/%b exp=1/0005/0", k, imem.i_readM, imem.i_address, if_id_valid); end
    end
    ready = 1'b1;
    step();
    tests++; if (bundle !== {1'b1, 16'h1005, 16'h0005, 16'h0006, 1'b0}) begin
      fails++; $display("FAIL wait_done got=%h exp=%h", bundle, {1'b1, 16'h1005, 16'h0005, 16'h0006, 1'b0}); end
    step();
  endtask

  task automatic test_stall();
    stall_id = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      tests++; if (imem.i_readM !== 1'b0) begin fails++; $display("FAIL hold_readM[%0d] got=%b exp=0", k, imem.i_readM); end
      tests++; if ({bundle, fetch_pc} !== {1'b1, 16'h1006, 16'h0006, 16'h0007, 1'b0, 16'h0008}) begin
        fails++; $display("FAIL hold_ifid[%0d] got=%h/%h exp=instr6 pc8", k, bundle, fetch_pc); end
    end
    stall_id = 1'b0;
    step();
    tests++; if (bundle !== {1'b1, 16'h1007, 16'h0007, 16'h0008, 1'b0}) begin
      fails++; $display("FAIL hold_release got=%h exp=%h", bundle, {1'b1, 16'h1007, 16'h0007, 16'h0008, 1'b0}); end
    tests++; if ({imem.i_readM, imem.i_address} !== {1'b1, 16'h0008}) begin
      fails++; $display("FAIL hold_resume got=%b/%h exp=1/0008", imem.i_readM, imem.i_address); end
    step();
    tests++; if (bundle !== {1'b1, 16'h1008, 16'h0008, 16'h0009, 1'b0}) begin
      fails++; $display("FAIL hold_next got=%h exp=%h", bundle, {1'b1, 16'h1008, 16'h0008, 16'h0009, 1'b0}); end
  endtask

  task automatic test_flush_pending();
    ready = 1'b0; flush = 1'b1; redirect_pc = 16'h0040;
    step();
    tests++; if ({imem.i_readM, imem.i_address, if_id_valid, fetch_pc} !== {1'b1, 16'h0009, 1'b0, 16'h0040}) begin
      fails++; $display("FAIL drop_enter got=%b/%h/%b/%h exp=1/0009/0/0040", imem.i_readM, imem.i_address, if_id_valid, fetch_pc); end
    flush = 1'b0;
    step();
    tests++; if ({imem.i_address, if_id_valid} !== {16'h0009, 1'b0}) begin
      fails++; $display("FAIL drop_wait got=%h/%b exp=0009/0", imem.i_address, if_id_valid); end
    ready = 1'b1;
    step();
    tests++; if ({imem.i_address, if_id_valid} !== {16'h0040, 1'b0}) begin
      fails++; $display("FAIL drop_done got=%h/%b exp=0040/0", imem.i_address, if_id_valid); end
    step();
    tests++; if (bundle !== {1'b1, 16'h1040, 16'h0040, 16'h0041, 1'b0}) begin
      fails++; $display("FAIL drop_redirect got=%h exp=%h", bundle, {1'b1, 16'h1040, 16'h0040, 16'h0041, 1'b0}); end
  endtask

  task automatic test_predict();
    flush = 1'b1; redirect_pc = 16'h0003;
    step();
    tests++; if ({imem.i_address, if_id_valid} !== {16'h0003, 1'b0}) begin
      fails++; $display("FAIL flush_ready got=%h/%b exp=0003/0", imem.i_address, if_id_valid); end
    flush = 1'b0; bp_force = 1'b1; bp_force_pc = 16'h0020; bp_force_tag = 1'b1;
    step();
    bp_force = 1'b0;
    tests++; if (bundle !== {1'b1, 16'h1003, 16'h0003, 16'h0020, 1'b1}) begin
      fails++; $display("FAIL pred_ifid got=%h exp=%h", bundle, {1'b1, 16'h1003, 16'h0003, 16'h0020, 1'b1}); end
    tests++; if (imem.i_address !== 16'h0020) begin fails++; $display("FAIL pred_next got=%h exp=0020", imem.i_address); end
    step();
    tests++; if (bundle !== {1'b1, 16'h1020, 16'h0020, 16'h0021, 1'b0}) begin
      fails++; $display("FAIL pred_follow got=%h exp=%h", bundle, {1'b1, 16'h1020, 16'h0020, 16'h0021, 1'b0}); end
  endtask

  task automatic test_flush_in_hold();
    stall_id = 1'b1;
    step();
    tests++; if (imem.i_readM !== 1'b0) begin fails++; $display("FAIL fh_hold got=%b exp=0", imem.i_readM); end
    flush = 1'b1; redirect_pc = 16'h0050;
    step();
    tests++; if ({imem.i_readM, imem.i_address, if_id_valid} !== {1'b1, 16'h0050, 1'b0}) begin
      fails++; $display("FAIL fh_flush got=%b/%h/%b exp=1/0050/0", imem.i_readM, imem.i_address, if_id_valid); end
    flush = 1'b0; stall_id = 1'b0;
    step();
    tests++; if (bundle !== {1'b1, 16'h1050, 16'h0050, 16'h0051, 1'b0}) begin
      fails++; $display("FAIL fh_after got=%h exp=%h", bundle, {1'b1, 16'h1050, 16'h0050, 16'h0051, 1'b0}); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; redirect_pc = 16'hFFFF;
    step();
    flush = 1'b0;
    step();
    tests++; if (bundle !== {1'b1, 16'h0FFF, 16'hFFFF, 16'h0000, 1'b0}) begin
      fails++; $display("FAIL wrap_ifid got=%h exp=%h", bundle, {1'b1, 16'h0FFF, 16'hFFFF, 16'h0000, 1'b0}); end
    tests++; if (imem.i_address !== 16'h0000) begin fails++; $display("FAIL wrap_addr got=%h exp=0000", imem.i_address); end
  endtask

  task automatic test_perf();
`ifdef IF_PERF_CNT_EN
    tests++; if (perf_fetch_cnt !== 16'd14) begin fails++; $display("FAIL perf_fetch got=%0d exp=14", perf_fetch_cnt); end
    tests++; if (perf_flush_cnt !== 16'd4) begin fails++; $display("FAIL perf_flush got=%0d exp=4", perf_flush_cnt); end
`endif
  endtask

  task automatic test_reset_mid_request();
    flush = 1'b1; redirect_pc = 16'h0030;
    step();
    flush = 1'b0; ready = 1'b0;
    step();
    tests++; if ({imem.i_readM, imem.i_address} !== {1'b1, 16'h0030}) begin
      fails++; $display("FAIL mid_req got=%b/%h exp=1/0030", imem.i_readM, imem.i_address); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if ({imem.i_readM, fetch_pc} !== {1'b0, 16'h0000}) begin
      fails++; $display("FAIL async_reset got=%b/%h exp=0/0000", imem.i_readM, fetch_pc); end
    tests++; if (bundle !== 50'd0) begin fails++; $display("FAIL async_ifid got=%h exp=0", bundle); end
    step();
    reset_n = 1'b1; ready = 1'b1;
    step();
    step();
    tests++; if (bundle !== {1'b1, 16'h1000, 16'h0000, 16'h0001, 1'b0}) begin
      fails++; $display("FAIL post_reset got=%h exp=%h", bundle, {1'b1, 16'h1000, 16'h0000, 16'h0001, 1'b0}); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_not_ready();
    test_stall();
    test_flush_pending();
    test_predict();
    test_flush_in_hold();
    test_wrap();
    test_perf();
    test_reset_mid_request();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
